// File: rtl/game_counter_pkg.sv
// Shared types for the parametrised game counter: step-mode encoding, result code and game-state encoding.
package game_counter_pkg;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UPS = 2'b01,
    DN1 = 2'b10,
    DNS = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_e;

  // Encodings line up with who_e so the result can be read straight off the state.
  typedef enum logic [1:0] {
    ST_PLAY      = 2'b00,
    ST_OVER_LOSE = 2'b01,
    ST_OVER_WIN  = 2'b10
  } game_state_e;

  function automatic who_e state_to_who(input game_state_e st);
    case (st)
      ST_OVER_WIN:  return WHO_WINNER;
      ST_OVER_LOSE: return WHO_LOSER;
      default:      return WHO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/game_score_tracker.sv
// Win/lose score counters with limit compare; flags game over for one cycle, then clears everything.
//
// state        | meaning
// ST_PLAY      | game running, scores advance on events
// ST_OVER_WIN  | win limit reached this cycle, GAMEOVER=1, WHO=winner
// ST_OVER_LOSE | lose limit reached this cycle, GAMEOVER=1, WHO=loser
module game_score_tracker
  import game_counter_pkg::*;
#(
  parameter int SCORE_W    = 4,
  parameter int WIN_LIMIT  = 15,
  parameter int LOSE_LIMIT = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               win_evt,
  input  logic               lose_evt,
  input  logic               clr,
  output logic [SCORE_W-1:0] count_winner,
  output logic [SCORE_W-1:0] count_loser,
  output logic               GAMEOVER,
  output logic [1:0]         WHO
);

  localparam logic [SCORE_W-1:0] WIN_L  = SCORE_W'(WIN_LIMIT);
  localparam logic [SCORE_W-1:0] LOSE_L = SCORE_W'(LOSE_LIMIT);
  localparam logic [SCORE_W-1:0] ONE    = SCORE_W'(1);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] win_q, win_d;
  logic [SCORE_W-1:0] lose_q, lose_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_PLAY;
      win_q   <= '0;
      lose_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  // The limit compare uses the post-increment scores so GAMEOVER lands with the final event pulse.
  always_comb begin
    state_d = ST_PLAY;
    win_d   = win_q;
    lose_d  = lose_q;
    if (clr || state_q != ST_PLAY) begin
      win_d  = '0;
      lose_d = '0;
    end else begin
      if (win_evt)  win_d  = win_q + ONE;
      if (lose_evt) lose_d = lose_q + ONE;
      if (win_evt || lose_evt) begin
        if (win_d == WIN_L)        state_d = ST_OVER_WIN;
        else if (lose_d == LOSE_L) state_d = ST_OVER_LOSE;
      end
    end
  end

  always_comb begin
    GAMEOVER     = (state_q != ST_PLAY);
    WHO          = state_to_who(state_q);
    count_winner = win_q;
    count_loser  = lose_q;
  end

endmodule

// File: rtl/game_counter_param.sv
// Parametrised up/down game counter: step/wrap/saturate datapath and boundary event detection.
module game_counter_param
  import game_counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int SCORE_W    = 4,
  parameter int STEP       = 2,
  parameter int WIN_LIMIT  = 15,
  parameter int LOSE_LIMIT = 15,
  parameter int SATURATE   = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               INIT,
  input  logic [1:0]         CONTROL,
  input  logic [WIDTH-1:0]   load,
  output logic [WIDTH-1:0]   count,
  output logic [SCORE_W-1:0] count_winner,
  output logic [SCORE_W-1:0] count_loser,
  output logic               WINNER,
  output logic               LOSER,
  output logic               GAMEOVER,
  output logic [1:0]         WHO
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
  localparam bit             SAT    = (SATURATE != 0);

  ctrl_e            mode;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   diff_x;
  logic [WIDTH-1:0] count_q, count_nx;
  logic             upd;
  logic             win_evt, lose_evt;
  logic             winner_q, loser_q;
  logic             game_over;

  assign mode = ctrl_e'(CONTROL);

  // One extra bit catches carry/borrow, which drives the clamp when saturating.
  always_comb begin
    step_x = (mode == UPS || mode == DNS) ? STEP_X : ONE_X;
    sum_x  = {1'b0, count_q} + step_x;
    diff_x = {1'b0, count_q} - step_x;
  end

  always_comb begin
    count_nx = count_q;
    upd      = 1'b0;
    if (INIT) begin
      count_nx = load;
      upd      = 1'b1;
    end else if (EN) begin
      upd = 1'b1;
      case (mode)
        UP1, UPS: count_nx = (SAT && sum_x[WIDTH])  ? '1 : sum_x[WIDTH-1:0];
        default:  count_nx = (SAT && diff_x[WIDTH]) ? '0 : diff_x[WIDTH-1:0];
      endcase
    end
  end

  // The clear cycle after game over must not score, even though count returns to 0.
  always_comb begin
    win_evt  = upd && !game_over && (count_nx == '1);
    lose_evt = upd && !game_over && (count_nx == '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q  <= '0;
      winner_q <= 1'b0;
      loser_q  <= 1'b0;
    end else if (game_over) begin
      count_q  <= '0;
      winner_q <= 1'b0;
      loser_q  <= 1'b0;
    end else begin
      count_q  <= count_nx;
      winner_q <= win_evt;
      loser_q  <= lose_evt;
    end
  end

  game_score_tracker #(
    .SCORE_W   (SCORE_W),
    .WIN_LIMIT (WIN_LIMIT),
    .LOSE_LIMIT(LOSE_LIMIT)
  ) u_score (
    .CLK         (CLK),
    .RST         (RST),
    .win_evt     (win_evt),
    .lose_evt    (lose_evt),
    .clr         (game_over),
    .count_winner(count_winner),
    .count_loser (count_loser),
    .GAMEOVER    (game_over),
    .WHO         (WHO)
  );

  assign count    = count_q;
  assign WINNER   = winner_q;
  assign LOSER    = loser_q;
  assign GAMEOVER = game_over;

endmodule

// File: tb/tb_game_counter_param.sv
// Directed bench for game_counter_param: defaults (a), saturating (b) and short-limit (c) instances.
module tb_game_counter_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en_a, init_a, en_b, init_b, en_c, init_c;
  logic [1:0] ctrl_a, ctrl_b, ctrl_c;
  logic [3:0] ld_a, ld_b, ld_c;
  logic [3:0] cnt_a, cw_a, cl_a, cnt_b, cw_b, cl_b, cnt_c, cw_c, cl_c;
  logic       win_a, los_a, go_a, win_b, los_b, go_b, win_c, los_c, go_c;
  logic [1:0] who_a, who_b, who_c;

  game_counter_param u_a (
    .CLK(clk), .RST(rst), .EN(en_a), .INIT(init_a), .CONTROL(ctrl_a), .load(ld_a),
    .count(cnt_a), .count_winner(cw_a), .count_loser(cl_a),
    .WINNER(win_a), .LOSER(los_a), .GAMEOVER(go_a), .WHO(who_a));

  game_counter_param #(.SATURATE(1)) u_b (
    .CLK(clk), .RST(rst), .EN(en_b), .INIT(init_b), .CONTROL(ctrl_b), .load(ld_b),
    .count(cnt_b), .count_winner(cw_b), .count_loser(cl_b),
    .WINNER(win_b), .LOSER(los_b), .GAMEOVER(go_b), .WHO(who_b));

  game_counter_param #(.WIN_LIMIT(3), .LOSE_LIMIT(2)) u_c (
    .CLK(clk), .RST(rst), .EN(en_c), .INIT(init_c), .CONTROL(ctrl_c), .load(ld_c),
    .count(cnt_c), .count_winner(cw_c), .count_loser(cl_c),
    .WINNER(win_c), .LOSER(los_c), .GAMEOVER(go_c), .WHO(who_c));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int cnt, input int cw, input int cl,
                       input int w, input int l, input int go, input int who);
    chk({tag, ".a.count"}, int'(cnt_a), cnt);
    chk({tag, ".a.cw"},    int'(cw_a),  cw);
    chk({tag, ".a.cl"},    int'(cl_a),  cl);
    chk({tag, ".a.win"},   int'(win_a), w);
    chk({tag, ".a.lose"},  int'(los_a), l);
    chk({tag, ".a.go"},    int'(go_a),  go);
    chk({tag, ".a.who"},   int'(who_a), who);
  endtask

  task automatic chk_b(input string tag, input int cnt, input int cw, input int cl,
                       input int w, input int l, input int go, input int who);
    chk({tag, ".b.count"}, int'(cnt_b), cnt);
    chk({tag, ".b.cw"},    int'(cw_b),  cw);
    chk({tag, ".b.cl"},    int'(cl_b),  cl);
    chk({tag, ".b.win"},   int'(win_b), w);
    chk({tag, ".b.lose"},  int'(los_b), l);
    chk({tag, ".b.go"},    int'(go_b),  go);
    chk({tag, ".b.who"},   int'(who_b), who);
  endtask

  task automatic chk_c(input string tag, input int cnt, input int cw, input int cl,
                       input int w, input int l, input int go, input int who);
    chk({tag, ".c.count"}, int'(cnt_c), cnt);
    chk({tag, ".c.cw"},    int'(cw_c),  cw);
    chk({tag, ".c.cl"},    int'(cl_c),  cl);
    chk({tag, ".c.win"},   int'(win_c), w);
    chk({tag, ".c.lose"},  int'(los_c), l);
    chk({tag, ".c.go"},    int'(go_c),  go);
    chk({tag, ".c.who"},   int'(who_c), who);
  endtask

  initial begin
    en_a = 0; init_a = 0; ctrl_a = 2'b00; ld_a = 4'd0;
    en_b = 0; init_b = 0; ctrl_b = 2'b00; ld_b = 4'd0;
    en_c = 0; init_c = 0; ctrl_c = 2'b00; ld_c = 4'd0;

    // reset and idle
    #3;
    chk_a("rst", 0, 0, 0, 0, 0, 0, 0);
    #9 rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk_a("idle", 0, 0, 0, 0, 0, 0, 0);
    chk_b("idle", 0, 0, 0, 0, 0, 0, 0);
    chk_c("idle", 0, 0, 0, 0, 0, 0, 0);

    // a: load 13, +STEP to 15 (win), +STEP wraps to 1
    init_a = 1; ld_a = 4'd13;
    tick(); chk_a("load13", 13, 0, 0, 0, 0, 0, 0);
    init_a = 0; en_a = 1; ctrl_a = 2'b01;
    tick(); chk_a("up2_15", 15, 1, 0, 1, 0, 0, 0);
    tick(); chk_a("wrap1", 1, 1, 0, 0, 0, 0, 0);
    ctrl_a = 2'b10;
    tick(); chk_a("dn1_0", 0, 1, 1, 0, 1, 0, 0);
    ctrl_a = 2'b11;
    tick(); chk_a("dn2_14", 14, 1, 1, 0, 0, 0, 0);
    ctrl_a = 2'b00;
    tick(); chk_a("up1_15", 15, 2, 1, 1, 0, 0, 0);
    en_a = 0;
    tick(); chk_a("hold", 15, 2, 1, 0, 0, 0, 0);

    // b: saturating down-by-STEP re-fires at 0, then clamp at top
    init_b = 1; ld_b = 4'd1;
    tick(); chk_b("load1", 1, 0, 0, 0, 0, 0, 0);
    init_b = 0; en_b = 1; ctrl_b = 2'b11;
    tick(); chk_b("sat0_1", 0, 0, 1, 0, 1, 0, 0);
    tick(); chk_b("sat0_2", 0, 0, 2, 0, 1, 0, 0);
    en_b = 0; init_b = 1; ld_b = 4'd14;
    tick(); chk_b("load14", 14, 0, 2, 0, 0, 0, 0);
    init_b = 0; en_b = 1; ctrl_b = 2'b01;
    tick(); chk_b("sat15", 15, 1, 2, 1, 0, 0, 0);
    en_b = 0;

    // c: three loads of 15 reach WIN_LIMIT=3
    init_c = 1; ld_c = 4'd15;
    tick(); chk_c("w1", 15, 1, 0, 1, 0, 0, 0);
    tick(); chk_c("w2", 15, 2, 0, 1, 0, 0, 0);
    tick(); chk_c("w3", 15, 3, 0, 1, 0, 1, 2);
    init_c = 0;
    tick(); chk_c("wclr", 0, 0, 0, 0, 0, 0, 0);

    // c: two down-to-0 events reach LOSE_LIMIT=2; INIT ignored on clear cycle
    init_c = 1; ld_c = 4'd1;
    tick(); chk_c("l_ld1", 1, 0, 0, 0, 0, 0, 0);
    init_c = 0; en_c = 1; ctrl_c = 2'b10;
    tick(); chk_c("l1", 0, 0, 1, 0, 1, 0, 0);
    en_c = 0; init_c = 1; ld_c = 4'd1;
    tick(); chk_c("l_ld1b", 1, 0, 1, 0, 0, 0, 0);
    init_c = 0; en_c = 1;
    tick(); chk_c("l2", 0, 0, 2, 0, 1, 1, 1);
    en_c = 0; init_c = 1; ld_c = 4'd5;
    tick(); chk_c("lclr", 0, 0, 0, 0, 0, 0, 0);
    tick(); chk_c("ld5", 5, 0, 0, 0, 0, 0, 0);
    init_c = 0;

    // a: build count_winner to 7, then async reset between edges
    init_a = 1; ld_a = 4'd15;
    for (int i = 0; i < 5; i++) tick();
    chk_a("cw7", 15, 7, 1, 1, 0, 0, 0);
    init_a = 0;
    #2 rst = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    en_a = 1; ctrl_a = 2'b00;
    tick(); chk_a("post_rst", 1, 0, 0, 0, 0, 0, 0);
    en_a = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/game_counter_param.md
Name: game_counter_param

Overview:
- Parametrised successor of the 4-bit multi-mode up/down game counter.
- A WIDTH-bit counter moves by 1 or STEP, up or down, each enabled cycle.
- Hitting all-zeros scores a loss and hitting all-ones scores a win; each score runs up to its own limit.
- When either limit is reached, the block flags game over, reports the result on WHO and then self-clears.
- Adds the following over the previous generation: enable/hold, a configurable step, independent win/lose limits and optional saturation.

Parameters:
- WIDTH, 4, counter width in bits (min 2).
- SCORE_W, 4, width of each score counter.
- STEP, 2, magnitude of the large step (1 <= STEP < 2**WIDTH).
- WIN_LIMIT, 15, win score that ends the game (1 .. 2**SCORE_W-1).
- LOSE_LIMIT, 15, lose score that ends the game (1 .. 2**SCORE_W-1).
- SATURATE, 0, 0 = modulo wrap, 1 = clamp at 0 and at 2**WIDTH-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  count enable; 0 holds the counter.
- INIT  in  1  synchronous load of `load`; priority over EN.
- CONTROL  in  2  step mode: 00 = +1, 01 = +STEP, 10 = -1, 11 = -STEP.
- load  in  WIDTH  initial value.
- count  out  WIDTH  current counter value.
- count_winner  out  SCORE_W  win score.
- count_loser  out  SCORE_W  lose score.
- WINNER  out  1  one-cycle pulse on a win event.
- LOSER  out  1  one-cycle pulse on a lose event.
- GAMEOVER  out  1  one-cycle pulse when a limit is reached.
- WHO  out  2  result: 00 = none, 01 = loser, 10 = winner.

Behaviour:
- Reset (RST=0, asynchronous): count=0, both scores=0, WINNER=0, LOSER=0, GAMEOVER=0, WHO=00. No event is generated on reset release.
- All outputs are registered. Each rising edge evaluates the rules below in priority order.
- 1) GAMEOVER=1 (clear cycle):
  - count=0, both scores=0, WHO=00, GAMEOVER=0, WINNER=0, LOSER=0.
  - INIT, EN and CONTROL are ignored.
  - No event is generated, even though count becomes 0.
- 2) INIT=1: count_next = load; the update flag is set.
- 3) EN=1: count_next = count +/- (1 or STEP) per CONTROL; the update flag is set.
  - SATURATE=0: arithmetic is modulo 2**WIDTH (e.g. 14 + 2 = 0, 1 - 2 = 15 at WIDTH=4).
  - SATURATE=1: the result clamps to 0 or 2**WIDTH-1.
- 4) Otherwise: count holds and the update flag is clear.
- Events (only when the update flag is set):
  - count_next == 0: LOSER=1 and count_loser += 1.
  - count_next == 2**WIDTH-1: WINNER=1 and count_winner += 1.
  - The two conditions are mutually exclusive.
  - WINNER and LOSER are 0 on every cycle without an event, so a pulse lasts exactly 1 cycle.
  - An INIT load of 0 or of all-ones counts as an event.
  - A saturated or held-at-boundary counter re-fires the event on every enabled cycle.
- Game end (evaluated on the post-increment scores, same edge):
  - count_winner_next == WIN_LIMIT: GAMEOVER=1, WHO=10.
  - Else count_loser_next == LOSE_LIMIT: GAMEOVER=1, WHO=01.
  - Only one score can advance per cycle, so a tie is impossible.
  - The win check is listed first for determinism.
- Latency:
  - An event pulse appears 1 cycle after the causing edge's inputs are sampled.
  - GAMEOVER and WHO are asserted together with the final WINNER/LOSER pulse.
  - All state is cleared on the next edge.
- Scores never wrap: the limit is always reached before overflow.
- Reset asserted mid-game clears everything immediately, independent of CLK.
- EN=0 with INIT=0: count, scores and WHO hold; WINNER and LOSER are 0.

Decomposition:
- Package game_counter_pkg:
  - ctrl_e enum (UP1=2'b00, UPS=2'b01, DN1=2'b10, DNS=2'b11).
  - who_e enum (WHO_NONE=2'b00, WHO_LOSER=2'b01, WHO_WINNER=2'b10).
- Sub-module game_score_tracker:
  - Takes the event inputs win_evt, lose_evt and clr.
  - Owns both score counters, the limit compare, GAMEOVER and WHO.
  - Parametrised by SCORE_W, WIN_LIMIT and LOSE_LIMIT.
- The top level holds the step/wrap/saturate datapath and event detection.

Test Plan:
- Defaults; release reset with EN=0 for 3 cycles -> count=0, no LOSER, all outputs 0.
- INIT=1, load=13, then EN=1, CONTROL=01 -> count 13 -> 15 (WINNER pulse, count_winner=1) -> 1 (wrap, no event).
- SATURATE=1, count=1, EN=1, CONTROL=11 for 2 cycles -> count=0 both cycles, LOSER high both cycles, count_loser=2.
- WIN_LIMIT=3, repeated INIT with load=15 -> third load gives WINNER=1, GAMEOVER=1, WHO=10; next edge all zero, GAMEOVER=0, no LOSER.
- LOSE_LIMIT=2, two down-to-0 events -> GAMEOVER=1, WHO=01; on the clear cycle INIT=1, load=5 is ignored, so count=0.
- Pull RST low between clock edges with count_winner=7 -> all outputs 0 immediately; first enabled +1 after release gives count=1.
